// File: rtl/motion_decoder.sv
// Turns the signed vertical-acceleration sample stream into jump pulses (with height) and a run level/speed.
// Optional MOTION_SPEED_SMOOTH_EN averages each new run speed with the previous one.
module motion_decoder #(
   parameter int SAMPLE_W      = 16,
   parameter int JUMP_THRESH   = 4000,
   parameter int HEIGHT_SHIFT  = 4,
   parameter int MAX_RISE      = 64,
   parameter int COOLDOWN      = 8,
   parameter int STEP_THRESH   = 1500,
   parameter int STEP_HYST     = 500,
   parameter int WIN_FRAMES    = 30,
   parameter int SPEED_SCALE   = 64,
   parameter int RUN_MIN_STEPS = 2
) (
   input  logic                i_clk_pix,
   input  logic                i_rst_n,
   input  logic                i_sample_valid,
   input  logic [SAMPLE_W-1:0] i_sample,
   input  logic                i_frame,
   output logic                o_jump,
   output logic [SAMPLE_W-1:0] o_jump_height,
   output logic                o_run,
   output logic [15:0]         o_run_speed
);

   localparam int unsigned RISE_W  = $clog2(MAX_RISE + 1);
   localparam int unsigned COOL_W  = $clog2(COOLDOWN + 1);
   localparam int unsigned FRAME_W = $clog2(WIN_FRAMES);
   localparam int unsigned STEP_W  = 8;
   localparam int unsigned SPEED_W = 16;
   localparam int unsigned PROD_W  = STEP_W + SPEED_W;

   localparam logic signed [SAMPLE_W-1:0] JUMP_LVL  = SAMPLE_W'(JUMP_THRESH);
   localparam logic signed [SAMPLE_W-1:0] STEP_LVL  = SAMPLE_W'(STEP_THRESH);
   localparam logic signed [SAMPLE_W-1:0] REARM_LVL = SAMPLE_W'(STEP_THRESH - STEP_HYST);

   typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, COOL = 2'd2} state_t;

   state_t                     state, state_nxt;
   logic signed [SAMPLE_W-1:0] smp;
   logic signed [SAMPLE_W-1:0] peak;
   logic [RISE_W-1:0]          rise_cnt;
   logic [COOL_W-1:0]          cool_cnt;
   logic [STEP_W-1:0]          steps;
   logic                       armed;
   logic [FRAME_W-1:0]         frame_cnt;

   logic                       ge_jump;
   logic [RISE_W-1:0]          rise_inc;
   logic                       jump_fire_c;
   logic [SAMPLE_W-1:0]        height_c;
   logic                       step_hit_c;
   logic                       win_end_c;
   logic                       run_c;
   logic [PROD_W-1:0]          prod_c;
   logic [SPEED_W-1:0]         new_speed_c;
   logic [SPEED_W-1:0]         speed_nxt_c;
   logic [SPEED_W:0]           sum_c;

   assign smp      = i_sample;
   assign ge_jump  = (smp >= JUMP_LVL);
   assign rise_inc = rise_cnt + RISE_W'(1);

   // State register
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the FSM only moves on accepted samples
   always_comb begin
      state_nxt = state;
      if (i_sample_valid) begin
         case (state)
            IDLE:    if (ge_jump) state_nxt = RISE;
            RISE:    if (!ge_jump || rise_inc == RISE_W'(MAX_RISE)) state_nxt = COOL;
            COOL:    if (cool_cnt <= COOL_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output decode: jump termination, step detection and window-end results
   always_comb begin
      jump_fire_c = i_sample_valid && (state == RISE) && !ge_jump;
      height_c    = SAMPLE_W'(peak - JUMP_LVL) >> HEIGHT_SHIFT;
      step_hit_c  = i_sample_valid && (state == IDLE) && armed &&
                    (smp >= STEP_LVL) && !ge_jump;
      win_end_c   = i_frame && (frame_cnt == FRAME_W'(WIN_FRAMES - 1));
      run_c       = (steps >= STEP_W'(RUN_MIN_STEPS));
      prod_c      = PROD_W'(steps) * PROD_W'(SPEED_SCALE);
      new_speed_c = '0;
      if (run_c)
         new_speed_c = (prod_c > PROD_W'(16'hFFFF)) ? 16'hFFFF : SPEED_W'(prod_c);
      sum_c       = (SPEED_W+1)'(o_run_speed) + (SPEED_W+1)'(new_speed_c);
`ifdef MOTION_SPEED_SMOOTH_EN
      speed_nxt_c = SPEED_W'(sum_c >> 1);
`else
      speed_nxt_c = new_speed_c;
`endif
   end

   // Jump datapath: peak tracking, rise length and cooldown counters
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) begin
         peak     <= '0;
         rise_cnt <= '0;
         cool_cnt <= '0;
      end else if (i_sample_valid) begin
         case (state)
            IDLE: if (ge_jump) begin
               peak     <= smp;
               rise_cnt <= RISE_W'(1);
            end
            RISE: begin
               if (ge_jump) begin
                  rise_cnt <= rise_inc;
                  if (smp > peak) peak <= smp;
               end
               if (state_nxt == COOL) cool_cnt <= COOL_W'(COOLDOWN);
            end
            COOL:    if (cool_cnt != '0) cool_cnt <= cool_cnt - COOL_W'(1);
            default: ;
         endcase
      end
   end

   // Step counting with hysteresis; a step on the window-end cycle opens the new window
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) begin
         steps     <= '0;
         armed     <= 1'b1;
         frame_cnt <= '0;
      end else begin
         if (i_sample_valid && smp < REARM_LVL) armed <= 1'b1;
         else if (step_hit_c)                   armed <= 1'b0;

         if (win_end_c)                     steps <= step_hit_c ? STEP_W'(1) : '0;
         else if (step_hit_c && steps != '1) steps <= steps + STEP_W'(1);

         if (win_end_c)    frame_cnt <= '0;
         else if (i_frame) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

   // Registered outputs
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) begin
         o_jump        <= 1'b0;
         o_jump_height <= '0;
         o_run         <= 1'b0;
         o_run_speed   <= '0;
      end else begin
         o_jump <= jump_fire_c;
         if (jump_fire_c) o_jump_height <= height_c;
         if (win_end_c) begin
            o_run       <= run_c;
            o_run_speed <= speed_nxt_c;
         end
      end
   end

endmodule
